// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB master that turns register-access commands into APB SETUP/ACCESS
// transfers. Commands arrive on a valid/ready port and are buffered in a
// small FIFO. The FSM pops one command at a time and drives the APB bus.
// Each finished transfer (normal completion or pready timeout) is returned
// on a valid/ready response port. Only one transfer is in flight at a time,
// and a new one starts only once the previous response has been taken.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (cmd_ready = FIFO not full)
//   cmd_addr, cmd_wdata,      command address, write data, op (0 = write,
//   cmd_op                    1 = read)
//   rsp_valid / rsp_ready     response handshake
//   rsp_addr, rsp_data,       completed transfer: address, read data or
//   rsp_op, rsp_err           echoed write data (0 on error), op, timeout flag
//   paddr, psel, penable,     APB request signals
//   pwrite, pwdata
//   prdata, pready            APB completion signals
// ---------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int DATAW       = 32,
    parameter int ADDRW       = 32,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ADDRW-1:0] cmd_addr,
    input  logic [DATAW-1:0] cmd_wdata,
    input  logic             cmd_op,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ADDRW-1:0] rsp_addr,
    output logic [DATAW-1:0] rsp_data,
    output logic             rsp_op,
    output logic             rsp_err,

    output logic [ADDRW-1:0] paddr,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [DATAW-1:0] pwdata,
    input  logic [DATAW-1:0] prdata,
    input  logic             pready
);

    localparam int PTRW = $clog2(CMD_DEPTH);
    localparam int CNTW = $clog2(TIMEOUT_CYC);
    localparam int ENTW = 1 + ADDRW + DATAW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, next_state;

    logic [ENTW-1:0] fifo_mem [CMD_DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    logic [ENTW-1:0]  head;
    logic             head_op;
    logic [ADDRW-1:0] head_addr;
    logic [DATAW-1:0] head_wdata;

    logic [CNTW-1:0] wait_cnt;
    logic            wait_last;
    logic            xfer_ok;
    logic            xfer_timeout;

    assign fifo_full  = (count == (PTRW+1)'(CMD_DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;

    assign head = fifo_mem[rd_ptr];
    assign {head_op, head_addr, head_wdata} = head;

    assign wait_last    = (wait_cnt == CNTW'(TIMEOUT_CYC - 1));
    assign xfer_ok      = (state == ACCESS) && pready;
    assign xfer_timeout = (state == ACCESS) && !pready && wait_last;

    // Command FIFO storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_wdata};
        end
    end

    // Pointers wrap naturally because CMD_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A transfer only starts when the response register is free or is being
    // drained on this same edge, so the response can never be overwritten.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && (!rsp_valid || rsp_ready)) begin
                    next_state = SETUP;
                    pop        = 1'b1;
                end
            end
            SETUP:   next_state = ACCESS;
            ACCESS: begin
                if (pready || wait_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // APB request registers: loaded from the FIFO head on the pop edge and
    // held through SETUP and ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (pop) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= head_addr;
            pwrite  <= !head_op;
            pwdata  <= head_op ? '0 : head_wdata;
        end else if (state == SETUP) begin
            penable <= 1'b1;
        end else if (xfer_ok || xfer_timeout) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    // Counts ACCESS cycles spent with pready low; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (pop) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready && !wait_last) begin
            wait_cnt <= wait_cnt + CNTW'(1);
        end
    end

    // Write responses echo pwdata, which still holds the command's wdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_op    <= 1'b0;
        end else if (xfer_ok) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_addr  <= paddr;
            rsp_op    <= !pwrite;
            rsp_data  <= pwrite ? pwdata : prdata;
        end else if (xfer_timeout) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_addr  <= paddr;
            rsp_op    <= !pwrite;
            rsp_data  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
